multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout and illegal-op detection.
// Optional: define IMM_ALU_EN to add ADDI/ORI through the IEXEC/IWB states.
module multicycle_ctrl #(
  parameter int unsigned ALUCTR_W = 3,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_rdy,
  output logic                PCWr,
  output logic                IRWr,
  output logic                RegWr,
  output logic                MemRd,
  output logic                MemWr,
  output logic                RegDst,
  output logic                ExtOp,
  output logic                ALUsrcA,
  output logic                MemtoReg,
  output logic                IorD,
  output logic [1:0]          ALUsrcB,
  output logic [1:0]          PCsrc,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [3:0]          state,
  output logic                illegal,
  output logic                mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef IMM_ALU_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [WAIT_W-1:0] TMAX = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              run_q;
  logic              waiting;
  logic [2:0]        alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    waiting     = 1'b0;
    alu_op      = ALU_ADD;
    PCWr        = 1'b0;
    IRWr        = 1'b0;
    RegWr       = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    RegDst      = 1'b0;
    ExtOp       = 1'b0;
    ALUsrcA     = 1'b0;
    MemtoReg    = 1'b0;
    IorD        = 1'b0;
    ALUsrcB     = 2'd0;
    PCsrc       = 2'd0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    // run_q holds the FSM quiet until the first edge after reset release.
    if (!run_q) begin
      ALUsrcB = 2'd1;
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          MemRd   = 1'b1;
          ALUsrcB = 2'd1;
          if (mem_rdy) begin
            PCWr    = 1'b1;
            IRWr    = 1'b1;
            state_d = S_DECODE;
          end else if (wcnt_q == TMAX) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end else begin
            waiting = 1'b1;
          end
        end
        S_DECODE: begin
          ALUsrcB = 2'd3;
          ExtOp   = 1'b1;
          case (op)
            OP_R:         state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
`ifdef IMM_ALU_EN
            OP_ADDI, OP_ORI: state_d = S_IEXEC;
`endif
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          ALUsrcA = 1'b1;
          state_d = S_RWB;
          case (func)
            FN_ADD: alu_op = ALU_ADD;
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_RWB: begin
          RegWr   = 1'b1;
          RegDst  = 1'b1;
          state_d = S_FETCH;
        end
        S_MEMADR: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'd2;
          ExtOp   = 1'b1;
          state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRd = 1'b1;
          IorD  = 1'b1;
          if (mem_rdy) begin
            state_d = S_MEMWB;
          end else if (wcnt_q == TMAX) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end else begin
            waiting = 1'b1;
          end
        end
        S_MEMWR: begin
          MemWr = 1'b1;
          IorD  = 1'b1;
          if (mem_rdy) begin
            state_d = S_FETCH;
          end else if (wcnt_q == TMAX) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end else begin
            waiting = 1'b1;
          end
        end
        S_MEMWB: begin
          RegWr    = 1'b1;
          MemtoReg = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUsrcA = 1'b1;
          alu_op  = ALU_SUB;
          PCsrc   = 2'd1;
          PCWr    = zero;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          PCWr    = 1'b1;
          PCsrc   = 2'd2;
          state_d = S_FETCH;
        end
`ifdef IMM_ALU_EN
        S_IEXEC: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'd2;
          if (op == OP_ORI) begin
            alu_op = ALU_OR;
          end else begin
            ExtOp  = 1'b1;
            alu_op = ALU_ADD;
          end
          state_d = S_IWB;
        end
        S_IWB: begin
          RegWr   = 1'b1;
          state_d = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Counter is zero whenever the FSM is not stalled, so every entry starts from zero.
  assign wcnt_d = waiting ? wcnt_q + 1'b1 : '0;

  assign ALUctr = ALUCTR_W'(alu_op);
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default and WAIT_W=2 instances).
module tb_multicycle_ctrl;

  logic       clk, rst_n;
  logic [5:0] op, func;
  logic       zero, mem_rdy, mem_rdy_w2;

  logic       PCWr, IRWr, RegWr, MemRd, MemWr, RegDst, ExtOp, ALUsrcA, MemtoReg, IorD;
  logic [1:0] ALUsrcB, PCsrc;
  logic [2:0] ALUctr;
  logic [3:0] state;
  logic       illegal, mem_timeout;

  logic       PCWr_w2, IRWr_w2, RegWr_w2, MemRd_w2, MemWr_w2, RegDst_w2, ExtOp_w2;
  logic       ALUsrcA_w2, MemtoReg_w2, IorD_w2;
  logic [1:0] ALUsrcB_w2, PCsrc_w2;
  logic [2:0] ALUctr_w2;
  logic [3:0] state_w2;
  logic       illegal_w2, mem_timeout_w2;

  multicycle_ctrl #(.ALUCTR_W(3), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemRd(MemRd), .MemWr(MemWr),
    .RegDst(RegDst), .ExtOp(ExtOp), .ALUsrcA(ALUsrcA), .MemtoReg(MemtoReg), .IorD(IorD),
    .ALUsrcB(ALUsrcB), .PCsrc(PCsrc), .ALUctr(ALUctr), .state(state),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  multicycle_ctrl #(.ALUCTR_W(3), .WAIT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy_w2),
    .PCWr(PCWr_w2), .IRWr(IRWr_w2), .RegWr(RegWr_w2), .MemRd(MemRd_w2), .MemWr(MemWr_w2),
    .RegDst(RegDst_w2), .ExtOp(ExtOp_w2), .ALUsrcA(ALUsrcA_w2), .MemtoReg(MemtoReg_w2),
    .IorD(IorD_w2), .ALUsrcB(ALUsrcB_w2), .PCsrc(PCsrc_w2), .ALUctr(ALUctr_w2),
    .state(state_w2), .illegal(illegal_w2), .mem_timeout(mem_timeout_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Per-instruction observations collected by run_instr
  logic [31:0] trace;
  int cycles, n_regwr, n_memwr, n_pcwr, n_ill, n_to;
  int alu_x, regdst_x, m2r_x, pcsrc_b, pcwr_b;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting from FETCH; memory acks after `waits` stall cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int waits);
    int w;
    op = o; func = f; zero = z; w = 0;
    trace = '0; cycles = 0; n_regwr = 0; n_memwr = 0; n_pcwr = 0; n_ill = 0; n_to = 0;
    alu_x = -1; regdst_x = -1; m2r_x = -1; pcsrc_b = -1; pcwr_b = -1;
    do begin
      if (state == 4'd3 || state == 4'd5) begin
        mem_rdy = (w >= waits);
        w++;
      end else begin
        mem_rdy = (state == 4'd0);
      end
      #1;
      trace = {trace[27:0], state};
      n_regwr += int'(RegWr);
      n_memwr += int'(MemWr);
      n_pcwr  += int'(PCWr);
      n_ill   += int'(illegal);
      n_to    += int'(mem_timeout);
      if (state == 4'd6) alu_x = int'(ALUctr);
      if (RegWr) begin
        regdst_x = int'(RegDst);
        m2r_x    = int'(MemtoReg);
      end
      if (state == 4'd8) begin
        pcsrc_b = int'(PCsrc);
        pcwr_b  = int'(PCWr);
      end
      cycles++;
      cyc();
    end while (state != 4'd0 && cycles < 40);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  logic [5:0] ftab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  int         atab [5] = '{0, 1, 2, 3, 4};

  initial begin
    int k, irwr_seen;
    rst_n = 1'b0; op = '0; func = '0; zero = 1'b0; mem_rdy = 1'b0; mem_rdy_w2 = 1'b0;

    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_MemRd", int'(MemRd), 0);
    chk("rst_ALUsrcB", int'(ALUsrcB), 1);
    chk("rst_strobes", int'({PCWr, IRWr, RegWr, MemWr, illegal, mem_timeout}), 0);
    chk("rst_selects", int'({RegDst, ExtOp, ALUsrcA, MemtoReg, IorD, PCsrc, ALUctr}), 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pre_edge_MemRd", int'(MemRd), 0);
    cyc();
    chk("first_fetch_MemRd", int'(MemRd), 1);

    // WAIT_W=2 instance starved of mem_rdy in FETCH
    k = 0; irwr_seen = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      irwr_seen += int'(IRWr_w2);
      if (mem_timeout_w2) k = i;
      else cyc();
    end
    chk("w2_timeout_cycle", k, 4);
    chk("w4_no_timeout", int'(mem_timeout), 0);
    cyc();
    chk("w2_timeout_one_pulse", int'(mem_timeout_w2), 0);
    chk("w2_refetch", int'({MemRd_w2, state_w2}), 5'h10);
    chk("w2_IRWr_never", irwr_seen + int'(IRWr_w2), 0);

    do_reset();

    run_instr(6'b000000, 6'b100010, 1'b0, 0);
    chk("rsub_trace", int'(trace), 32'h0167);
    chk("rsub_alu", alu_x, 1);
    chk("rsub_regwr", n_regwr, 1);
    chk("rsub_regdst", regdst_x, 1);

    for (int i = 0; i < 5; i++) begin
      run_instr(6'b000000, ftab[i], 1'b0, 0);
      chk("rtab_trace", int'(trace), 32'h0167);
      chk("rtab_alu", alu_x, atab[i]);
    end

    run_instr(6'b100011, 6'b000000, 1'b0, 3);
    chk("lw_trace", int'(trace), 32'h01233334);
    chk("lw_cycles", cycles, 8);
    chk("lw_regwr", n_regwr, 1);
    chk("lw_memtoreg", m2r_x, 1);
    chk("lw_regdst", regdst_x, 0);

    run_instr(6'b101011, 6'b000000, 1'b0, 0);
    chk("sw_trace", int'(trace), 32'h0125);
    chk("sw_memwr", n_memwr, 1);
    chk("sw_regwr", n_regwr, 0);

    run_instr(6'b000100, 6'b000000, 1'b0, 0);
    chk("beq0_trace", int'(trace), 32'h018);
    chk("beq0_pcwr", pcwr_b, 0);
    chk("beq0_pcsrc", pcsrc_b, 1);
    run_instr(6'b000100, 6'b000000, 1'b1, 0);
    chk("beq1_pcwr", pcwr_b, 1);
    chk("beq1_pcsrc", pcsrc_b, 1);

    run_instr(6'b000010, 6'b000000, 1'b0, 0);
    chk("j_trace", int'(trace), 32'h019);
    chk("j_pcwr", n_pcwr, 2);

    run_instr(6'b111111, 6'b000000, 1'b0, 0);
    chk("badop_trace", int'(trace), 32'h01);
    chk("badop_illegal", n_ill, 1);
    chk("badop_writes", n_regwr + n_memwr + n_pcwr, 1);

    run_instr(6'b001000, 6'b000000, 1'b0, 0);
    chk("addi_illegal", n_ill, 1);
    chk("addi_trace", int'(trace), 32'h01);

    run_instr(6'b000000, 6'b000000, 1'b0, 0);
    chk("badfunc_trace", int'(trace), 32'h016);
    chk("badfunc_illegal", n_ill, 1);
    chk("badfunc_regwr", n_regwr, 0);

    run_instr(6'b101011, 6'b000000, 1'b0, 100);
    chk("swto_cycles", cycles, 19);
    chk("swto_timeout", n_to, 1);
    chk("swto_memwr", n_memwr, 16);
    chk("swto_regwr", n_regwr, 0);

    run_instr(6'b100011, 6'b000000, 1'b0, 15);
    chk("lw_tmax_cycles", cycles, 20);
    chk("lw_tmax_timeout", n_to, 0);
    chk("lw_tmax_regwr", n_regwr, 1);

    // Reset while a store is pending
    op = 6'b101011; mem_rdy = 1'b1;
    cyc();
    mem_rdy = 1'b0;
    cyc();
    cyc();
    chk("mw_in_memwr", int'({state, MemWr}), 5'h0B);
    rst_n = 1'b0;
    #1;
    chk("mw_rst_memwr", int'(MemWr), 0);
    chk("mw_rst_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("mw_refetch", int'(MemRd), 1);
    run_instr(6'b000000, 6'b100000, 1'b0, 0);
    chk("mw_after_trace", int'(trace), 32'h0167);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
